mpu_load_arbiter: RTL and testbench

- Shares the single mpu_load unit, and through it the register-file write port, between NREQ external matrix sources (host DMA, result write-back, etc.).
- Arbitrates pending load requests: round-robin by default, fixed priority when the optional feature is enabled.
- Holds the grant for the whole matrix transfer and muxes the granted requester's element stream and descriptor onto the load unit.
- Routes ack/error back to the granted requester and aborts stalled handshakes with a timeout.

---
 rtl/mpu_load_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mpu_load_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_load_arbiter.sv
// Arbiter sharing the single mpu_load unit between NREQ matrix sources.
// Round-robin by default; define MPU_LOAD_ARB_FIXED_PRIORITY_EN for fixed lowest-index priority.
module mpu_load_arbiter #(
    parameter int NREQ            = 2,
    parameter int TIMEOUT         = 16,
    parameter int FP              = 32,
    parameter int MBITS           = 3,
    parameter int NBITS           = 3,
    parameter int MATRIX_REG_SIZE = 3
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NREQ-1:0]                        req_en,
    input  logic [NREQ-1:0][FP-1:0]                req_element,
    input  logic [NREQ-1:0][MBITS:0]               req_m_size,
    input  logic [NREQ-1:0][NBITS:0]               req_n_size,
    input  logic [NREQ-1:0][MATRIX_REG_SIZE-1:0]   req_load_addr,
    output logic [NREQ-1:0]                        req_ack,
    output logic [NREQ-1:0]                        req_error,
    output logic [NREQ-1:0]                        grant,
    output logic                                   busy,
    output logic                                   load_en,
    output logic [FP-1:0]                          load_element,
    output logic [MBITS:0]                         load_m_size,
    output logic [NBITS:0]                         load_n_size,
    output logic [MATRIX_REG_SIZE-1:0]             load_addr,
    input  logic                                   load_ack,
    input  logic                                   load_error
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_START  = 2'd1,
        ARB_STREAM = 2'd2,
        ARB_DONE   = 2'd3
    } arb_state_t;

    arb_state_t          state_r, state_nx_s;
    logic [NREQ-1:0]     grant_r, grant_nx_s;
    logic [NREQ-1:0]     req_error_r, req_error_nx_s;
    logic [IW-1:0]       rr_ptr_r, rr_ptr_nx_s, rr_adv_s;
    logic [CW-1:0]       cnt_r, cnt_nx_s;
    logic                busy_r, load_en_r;

    logic [IW:0]         cand_s;
    logic [IW-1:0]       winner_idx_s;
    logic                found_s;
    logic                hit_s;

    // Pointer to the requester following the current owner (wraps at NREQ).
    function automatic logic [IW-1:0] next_ptr(input logic [NREQ-1:0] oh);
        logic [IW-1:0] idx;
        idx = {IW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            idx = idx | (oh[i] ? IW'(i) : {IW{1'b0}});
        end
        return (idx == IW'(NREQ - 1)) ? {IW{1'b0}} : idx + IW'(1);
    endfunction

    assign grant     = grant_r;
    assign req_error = req_error_r;
    assign busy      = busy_r;
    assign load_en   = load_en_r;
    assign req_ack   = grant_r & {NREQ{load_ack}};

    // Winner search starting at rr_ptr; rr_ptr stays 0 in the fixed-priority build.
    always_comb begin
        winner_idx_s = {IW{1'b0}};
        found_s      = 1'b0;
        cand_s       = {(IW+1){1'b0}};
        hit_s        = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s       = {1'b0, rr_ptr_r} + (IW+1)'(k);
            cand_s       = (cand_s >= (IW+1)'(NREQ)) ? cand_s - (IW+1)'(NREQ) : cand_s;
            hit_s        = !found_s && req_en[cand_s[IW-1:0]];
            winner_idx_s = hit_s ? cand_s[IW-1:0] : winner_idx_s;
            found_s      = found_s | hit_s;
        end
    end

    // Pointer value to adopt when the current transfer finishes.
    always_comb begin
`ifdef MPU_LOAD_ARB_FIXED_PRIORITY_EN
        rr_adv_s = {IW{1'b0}};
`else
        rr_adv_s = next_ptr(grant_r);
`endif
    end

    // Next-state and next-register logic of the arbitration FSM.
    always_comb begin
        state_nx_s     = state_r;
        grant_nx_s     = grant_r;
        rr_ptr_nx_s    = rr_ptr_r;
        cnt_nx_s       = cnt_r;
        req_error_nx_s = {NREQ{1'b0}};
        case (state_r)
            ARB_IDLE: begin
                cnt_nx_s = {CW{1'b0}};
                if (found_s) begin
                    grant_nx_s = {{(NREQ-1){1'b0}}, 1'b1} << winner_idx_s;
                    state_nx_s = ARB_START;
                end else begin
                    grant_nx_s = {NREQ{1'b0}};
                end
            end
            ARB_START: begin
                if (load_error) begin
                    req_error_nx_s = grant_r;
                    grant_nx_s     = {NREQ{1'b0}};
                    rr_ptr_nx_s    = rr_adv_s;
                    cnt_nx_s       = {CW{1'b0}};
                    state_nx_s     = ARB_DONE;
                end else if (load_ack) begin
                    cnt_nx_s   = {CW{1'b0}};
                    state_nx_s = ARB_STREAM;
                end else if (cnt_r >= CW'(TIMEOUT - 1)) begin
                    // Load unit never answered: abort this requester's handshake.
                    req_error_nx_s = grant_r;
                    grant_nx_s     = {NREQ{1'b0}};
                    rr_ptr_nx_s    = rr_adv_s;
                    cnt_nx_s       = {CW{1'b0}};
                    state_nx_s     = ARB_DONE;
                end else begin
                    cnt_nx_s = (cnt_r == {CW{1'b1}}) ? cnt_r : cnt_r + CW'(1);
                end
            end
            ARB_STREAM: begin
                if (!load_ack) begin
                    grant_nx_s  = {NREQ{1'b0}};
                    rr_ptr_nx_s = rr_adv_s;
                    state_nx_s  = ARB_DONE;
                end else begin
                    state_nx_s = ARB_STREAM;
                end
            end
            ARB_DONE: begin
                grant_nx_s = {NREQ{1'b0}};
                state_nx_s = ARB_IDLE;
            end
            default: begin
                grant_nx_s = {NREQ{1'b0}};
                cnt_nx_s   = {CW{1'b0}};
                state_nx_s = ARB_IDLE;
            end
        endcase
    end

    // FSM state and arbitration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ARB_IDLE;
            grant_r     <= {NREQ{1'b0}};
            req_error_r <= {NREQ{1'b0}};
            rr_ptr_r    <= {IW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            busy_r      <= 1'b0;
            load_en_r   <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            grant_r     <= grant_nx_s;
            req_error_r <= req_error_nx_s;
            rr_ptr_r    <= rr_ptr_nx_s;
            cnt_r       <= cnt_nx_s;
            busy_r      <= (state_nx_s != ARB_IDLE);
            load_en_r   <= (state_nx_s == ARB_START);
        end
    end

    // AND-OR mux of the granted requester's stream; zero when nobody owns the unit.
    always_comb begin
        load_element = {FP{1'b0}};
        load_m_size  = {(MBITS+1){1'b0}};
        load_n_size  = {(NBITS+1){1'b0}};
        load_addr    = {MATRIX_REG_SIZE{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            load_element = load_element | (req_element[i]   & {FP{grant_r[i]}});
            load_m_size  = load_m_size  | (req_m_size[i]    & {(MBITS+1){grant_r[i]}});
            load_n_size  = load_n_size  | (req_n_size[i]    & {(NBITS+1){grant_r[i]}});
            load_addr    = load_addr    | (req_load_addr[i] & {MATRIX_REG_SIZE{grant_r[i]}});
        end
    end

endmodule

// File: tb/tb_mpu_load_arbiter.sv
// Directed self-checking bench for mpu_load_arbiter; the bench plays the mpu_load unit.
module tb_mpu_load_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_en;
    logic [1:0][31:0] req_element;
    logic [1:0][3:0]  req_m_size;
    logic [1:0][3:0]  req_n_size;
    logic [1:0][2:0]  req_load_addr;
    logic [1:0]       req_ack, req_error, grant;
    logic             busy, load_en;
    logic [31:0]      load_element;
    logic [3:0]       load_m_size, load_n_size;
    logic [2:0]       load_addr;
    logic             load_ack, load_error;

    int errors = 0;
    int checks = 0;

    logic [31:0] vals [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                              32'h40800000, 32'h40A00000, 32'h40C00000};

    mpu_load_arbiter #(.NREQ(2), .TIMEOUT(16), .FP(32), .MBITS(3), .NBITS(3), .MATRIX_REG_SIZE(3)) dut (
        .clk(clk), .rst(rst), .req_en(req_en), .req_element(req_element),
        .req_m_size(req_m_size), .req_n_size(req_n_size), .req_load_addr(req_load_addr),
        .req_ack(req_ack), .req_error(req_error), .grant(grant), .busy(busy),
        .load_en(load_en), .load_element(load_element), .load_m_size(load_m_size),
        .load_n_size(load_n_size), .load_addr(load_addr),
        .load_ack(load_ack), .load_error(load_error));

    always #5 clk = ~clk;

    // Waits (bounded) until load_en is seen high at a sample point.
    task automatic wait_load_en(output bit ok);
        ok = 1'b0;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk); #1;
            if (load_en === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    // Acts as the load unit for one transfer of n_ack elements; the owner drops req_en on ack.
    task automatic serve(input int n_ack, output logic [1:0] owner, output bit ok);
        owner = 2'b00;
        wait_load_en(ok);
        if (ok) begin
            owner    = grant;
            load_ack = 1'b1;
            req_en   = req_en & ~owner;
            repeat (n_ack) @(negedge clk);
            load_ack = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_en = 2'b00; load_ack = 1'b0; load_error = 1'b0;
        req_element = '0; req_m_size = '0; req_n_size = '0; req_load_addr = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({grant, busy, load_en, req_ack, req_error} !== 8'h00) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=0", {grant, busy, load_en, req_ack, req_error});
        end
        checks++;
        if ({load_element, load_m_size, load_n_size, load_addr} !== 43'h0) begin
            errors++; $display("FAIL reset_data got=%h exp=0", {load_element, load_m_size, load_n_size, load_addr});
        end
        rst = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({grant, busy, load_en, req_error} !== 6'h00) begin
            errors++; $display("FAIL post_reset got=%b exp=0", {grant, busy, load_en, req_error});
        end
    endtask

    task automatic test_contention();
        logic [1:0] owner;
        logic [1:0] exp_o;
        bit ok;
        req_m_size[0] = 4'd1; req_n_size[0] = 4'd2; req_m_size[1] = 4'd2; req_n_size[1] = 4'd1;
        req_en = 2'b11;
        for (int r = 0; r < 4; r++) begin
`ifdef MPU_LOAD_ARB_FIXED_PRIORITY_EN
            exp_o = 2'b01;
`else
            exp_o = (r % 2 == 0) ? 2'b01 : 2'b10;
`endif
            serve(2, owner, ok);
            checks++;
            if (!ok || owner !== exp_o) begin
                errors++; $display("FAIL contention_round%0d got=%b exp=%b ok=%0d", r, owner, exp_o, ok);
            end
            req_en = (r == 3) ? 2'b00 : 2'b11;
        end
    endtask

    task automatic test_single();
        int ack_cnt = 0;
        int en_cnt  = 0;
        @(negedge clk);
        req_m_size[0] = 4'd2; req_n_size[0] = 4'd3; req_load_addr[0] = 3'd1;
        req_element[0] = vals[0]; req_en = 2'b01; load_ack = 1'b0;
        #1;
        checks++;
        if ({grant, busy} !== 3'b000) begin errors++; $display("FAIL single_pre got=%b exp=000", {grant, busy}); end
        @(negedge clk); #1;
        checks++;
        if ({grant, load_en, busy, req_ack} !== 6'b011100) begin
            errors++; $display("FAIL single_grant got=%b exp=011100", {grant, load_en, busy, req_ack});
        end
        if (load_en === 1'b1) en_cnt++;
        load_ack = 1'b1; req_en = 2'b00;
        #1;
        if (req_ack === 2'b01) ack_cnt++;
        checks++;
        if ({load_element, load_m_size, load_n_size, load_addr} !== {vals[0], 4'd2, 4'd3, 3'd1}) begin
            errors++; $display("FAIL single_desc got=%h exp=%h", {load_element, load_m_size, load_n_size, load_addr},
                               {vals[0], 4'd2, 4'd3, 3'd1});
        end
        for (int k = 1; k < 6; k++) begin
            @(negedge clk);
            req_element[0] = vals[k];
            #1;
            if (req_ack === 2'b01) ack_cnt++;
            if (load_en === 1'b1) en_cnt++;
            checks++;
            if (load_element !== vals[k]) begin
                errors++; $display("FAIL single_elem%0d got=%h exp=%h", k, load_element, vals[k]);
            end
        end
        @(negedge clk);
        load_ack = 1'b0;
        #1;
        checks++;
        if ({req_ack, busy} !== 3'b001) begin errors++; $display("FAIL single_ackfall got=%b exp=001", {req_ack, busy}); end
        @(negedge clk); #1;
        checks++;
        if ({grant, busy} !== 3'b001) begin errors++; $display("FAIL single_done got=%b exp=001", {grant, busy}); end
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got=%b exp=0", busy); end
        checks++;
        if (ack_cnt != 6 || en_cnt != 1) begin
            errors++; $display("FAIL single_counts ack=%0d en=%0d exp ack=6 en=1", ack_cnt, en_cnt);
        end
    endtask

    task automatic test_error();
        bit ok;
        req_m_size[1] = 4'd0; req_n_size[1] = 4'd3; req_en = 2'b10;
        wait_load_en(ok);
        checks++;
        if (!ok || grant !== 2'b10) begin errors++; $display("FAIL error_grant got=%b exp=10 ok=%0d", grant, ok); end
        load_error = 1'b1;
        #1;
        checks++;
        if ({req_ack, req_error} !== 4'b0000) begin
            errors++; $display("FAIL error_start got=%b exp=0000", {req_ack, req_error});
        end
        @(negedge clk);
        load_error = 1'b0; req_en = 2'b00;
        #1;
        checks++;
        if ({req_error, grant, busy, load_en, req_ack} !== 8'b10001000) begin
            errors++; $display("FAIL error_pulse got=%b exp=10001000", {req_error, grant, busy, load_en, req_ack});
        end
        @(negedge clk); #1;
        checks++;
        if ({req_error, busy} !== 3'b000) begin errors++; $display("FAIL error_end got=%b exp=000", {req_error, busy}); end
        // load_error wins over a simultaneous load_ack
        req_en = 2'b01;
        wait_load_en(ok);
        load_error = 1'b1; load_ack = 1'b1;
        @(negedge clk);
        load_error = 1'b0; load_ack = 1'b0; req_en = 2'b00;
        #1;
        checks++;
        if (!ok || {req_error, busy, load_en} !== 4'b0110) begin
            errors++; $display("FAIL error_priority got=%b exp=0110 ok=%0d", {req_error, busy, load_en}, ok);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        bit ok;
        int en_cnt = 0;
        bit early = 1'b0;
        req_en = 2'b01;
        wait_load_en(ok);
        if (ok) en_cnt = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (load_en !== 1'b1) break;
            en_cnt++;
            if (req_error !== 2'b00) early = 1'b1;
        end
        checks++;
        if (en_cnt != 16 || early) begin errors++; $display("FAIL timeout_len got=%0d exp=16 early=%0d", en_cnt, early); end
        checks++;
        if ({req_error, grant, busy} !== 5'b01001) begin
            errors++; $display("FAIL timeout_pulse got=%b exp=01001", {req_error, grant, busy});
        end
        req_en = 2'b00;
        @(negedge clk); #1;
        checks++;
        if ({req_error, busy} !== 3'b000) begin errors++; $display("FAIL timeout_idle got=%b exp=000", {req_error, busy}); end
    endtask

    task automatic test_late();
        bit ok;
        bit bad = 1'b0;
        req_m_size[0] = 4'd2; req_n_size[0] = 4'd2; req_en = 2'b01;
        wait_load_en(ok);
        checks++;
        if (!ok || grant !== 2'b01) begin errors++; $display("FAIL late_grant0 got=%b exp=01 ok=%0d", grant, ok); end
        load_ack = 1'b1; req_en = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_en = 2'b10;
            #1;
            if (grant !== 2'b01 || req_ack !== 2'b01) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL late_stream grant=%b ack=%b exp 01/01", grant, req_ack); end
        @(negedge clk);
        load_ack = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({grant, busy} !== 3'b001) begin errors++; $display("FAIL late_done got=%b exp=001", {grant, busy}); end
        @(negedge clk); #1;
        checks++;
        if ({grant, load_en} !== 3'b000) begin errors++; $display("FAIL late_idle got=%b exp=000", {grant, load_en}); end
        @(negedge clk); #1;
        checks++;
        if ({grant, load_en} !== 3'b101) begin errors++; $display("FAIL late_grant1 got=%b exp=101", {grant, load_en}); end
        load_error = 1'b1; req_en = 2'b00;
        @(negedge clk);
        load_error = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [1:0] owner;
        req_m_size[0] = 4'd4; req_n_size[0] = 4'd4; req_en = 2'b01;
        wait_load_en(ok);
        load_ack = 1'b1; req_en = 2'b00;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (!ok || {grant, busy} !== 3'b011) begin errors++; $display("FAIL rstmid_pre got=%b exp=011", {grant, busy}); end
        rst = 1'b1;
        #1;
        checks++;
        if ({grant, busy, load_en, req_ack, load_element} !== 38'h0) begin
            errors++; $display("FAIL rstmid_async got=%b %b %b %b %h exp=0", grant, busy, load_en, req_ack, load_element);
        end
        @(negedge clk);
        rst = 1'b0; load_ack = 1'b0; req_en = 2'b10;
        serve(3, owner, ok);
        checks++;
        if (!ok || owner !== 2'b10) begin errors++; $display("FAIL rstmid_next got=%b exp=10 ok=%0d", owner, ok); end
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_error();
        test_timeout();
        test_late();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
